// File: rtl/pzcorebus_pkg.sv
// Package: pzcorebus_pkg
// Purpose: corebus configuration type and helpers for deriving the packed
//          response layout. A packed response is {last, id, data} with the
//          last flag in the most significant bit.
// Contents:
//   pzcorebus_config                 - bus configuration (0 fields select defaults)
//   get_packed_response_width(cfg)   - total packed response width
//   get_response_last_position(cfg)  - bit index of the last flag
package pzcorebus_pkg;

  typedef struct packed {
    logic [7:0]  id_width;
    logic [15:0] data_width;
  } pzcorebus_config;

  localparam int DEFAULT_ID_WIDTH   = 4;
  localparam int DEFAULT_DATA_WIDTH = 16;

  function automatic int get_id_width(pzcorebus_config cfg);
    return (cfg.id_width == '0) ? DEFAULT_ID_WIDTH : int'(cfg.id_width);
  endfunction

  function automatic int get_data_width(pzcorebus_config cfg);
    return (cfg.data_width == '0) ? DEFAULT_DATA_WIDTH : int'(cfg.data_width);
  endfunction

  function automatic int get_packed_response_width(pzcorebus_config cfg);
    return 1 + get_id_width(cfg) + get_data_width(cfg);
  endfunction

  function automatic int get_response_last_position(pzcorebus_config cfg);
    return get_packed_response_width(cfg) - 1;
  endfunction

endpackage

// File: rtl/pzbcm_skid_buffer_sync.sv
// Module: pzbcm_skid_buffer_sync
// Purpose: 2-entry valid/ready skid buffer. Sustains one beat per cycle,
//          preserves order, and presents registered outputs downstream.
// Ports:
//   i_clk, i_rst      - clock, synchronous active-high reset (control only)
//   i_valid/o_ready   - upstream handshake; o_ready = fewer than 2 entries
//   i_data            - upstream data
//   o_valid/i_ready   - downstream handshake
//   o_data            - downstream data (head entry)
module pzbcm_skid_buffer_sync #(
  parameter int WIDTH = 8
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] mem [2];
  logic             push;
  logic             pop;

  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign o_data  = mem[rd_ptr];
  assign push    = i_valid & o_ready;
  assign pop     = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pzcorebus_response_arbiter.sv
// Module: pzcorebus_response_arbiter
// Purpose: merges SLAVES upstream response streams into one. Round-robin per
//          burst: a multi-beat response stays locked to its source until its
//          last beat. A grant presented but not accepted is held so the output
//          never changes while valid and unaccepted. Optional 2-entry skid
//          buffer on the output (REGISTERED_OUTPUT=1, latency 1).
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_sresp_valid    - per-source valid          o_mresp_accept - per-source accept
//   i_sresp          - per-source packed response
//   o_sresp_valid    - merged valid              i_mresp_accept - downstream accept
//   o_sresp          - merged packed response
//   o_grant          - one-hot source of the beat presented to the arbiter stage
module pzcorebus_response_arbiter
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = '0,
  parameter int              SLAVES = 2,
  parameter bit              REGISTERED_OUTPUT = 1,
  localparam int             RW = get_packed_response_width(BUS_CONFIG)
)(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [SLAVES-1:0]          i_sresp_valid,
  output logic [SLAVES-1:0]          o_mresp_accept,
  input  logic [SLAVES-1:0][RW-1:0]  i_sresp,
  output logic                       o_sresp_valid,
  input  logic                       i_mresp_accept,
  output logic [RW-1:0]              o_sresp,
  output logic [SLAVES-1:0]          o_grant
);

  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int unsigned       off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= SLAVES) s = s - SLAVES;
    return IDX_W'(s);
  endfunction

  logic              stage_ready;
  logic              vld_p0;
  logic [RW-1:0]     data_p0;
  logic [SLAVES-1:0] grant_p0;

  // ---- stage p0: source selection ----
  generate
    if (SLAVES == 1) begin : g_single
      assign vld_p0   = i_sresp_valid[0] & ~i_rst;
      assign data_p0  = i_sresp[0];
      assign grant_p0 = vld_p0;
    end else begin : g_arb
      localparam int LAST_POS = get_response_last_position(BUS_CONFIG);

      logic             lock;
      logic             hold;
      logic [IDX_W-1:0] lock_idx;
      logic [IDX_W-1:0] hold_idx;
      logic [IDX_W-1:0] rr_ptr;
      logic [IDX_W-1:0] gidx;
      logic             found;
      logic             push;

      // Lock outranks hold: a locked burst keeps its source even if a held
      // grant exists, and a held grant is never re-arbitrated.
      always_comb begin
        gidx  = rr_ptr;
        found = 1'b0;
        if (lock) begin
          gidx  = lock_idx;
          found = 1'b1;
        end else if (hold) begin
          gidx  = hold_idx;
          found = 1'b1;
        end else begin
          for (int unsigned k = 0; k < SLAVES; k++) begin
            if (!found && i_sresp_valid[wrap_add(rr_ptr, k)]) begin
              gidx  = wrap_add(rr_ptr, k);
              found = 1'b1;
            end
          end
        end
      end

      assign vld_p0  = found & i_sresp_valid[gidx] & ~i_rst;
      assign data_p0 = i_sresp[gidx];
      assign push    = vld_p0 & stage_ready;

      always_comb begin
        grant_p0       = '0;
        grant_p0[gidx] = vld_p0;
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          lock     <= 1'b0;
          hold     <= 1'b0;
          lock_idx <= '0;
          hold_idx <= '0;
          rr_ptr   <= '0;
        end else if (push) begin
          hold <= 1'b0;
          if (data_p0[LAST_POS]) begin
            lock   <= 1'b0;
            rr_ptr <= wrap_add(gidx, 1);
          end else begin
            lock     <= 1'b1;
            lock_idx <= gidx;
          end
        end else if (vld_p0) begin
          hold     <= 1'b1;
          hold_idx <= gidx;
        end else begin
          hold <= 1'b0;
        end
      end
    end
  endgenerate

  assign o_mresp_accept = grant_p0 & {SLAVES{stage_ready}};
  assign o_grant        = grant_p0;

  // ---- stage p1: optional output register ----
  generate
    if (REGISTERED_OUTPUT) begin : g_reg
      logic buf_ready;
      pzbcm_skid_buffer_sync #(
        .WIDTH (RW)
      ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (vld_p0),
        .o_ready (buf_ready),
        .i_data  (data_p0),
        .o_valid (o_sresp_valid),
        .i_ready (i_mresp_accept),
        .o_data  (o_sresp)
      );
      assign stage_ready = buf_ready;
    end else begin : g_comb
      assign stage_ready   = i_mresp_accept;
      assign o_sresp_valid = vld_p0;
      assign o_sresp       = data_p0;
    end
  endgenerate

endmodule

// File: tb/tb_pzcorebus_response_arbiter.sv
module tb_pzcorebus_response_arbiter;
  import pzcorebus_pkg::*;

  localparam int RW = 21;  // {last, id[3:0], data[15:0]} with default config

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 3 sources, registered output
  logic [2:0]         vld_in_a;
  logic [2:0]         accept_a;
  logic [2:0][RW-1:0] sresp_a;
  logic               valid_a;
  logic               acc_a;
  logic [RW-1:0]      data_a;
  logic [2:0]         grant_a;

  // DUT B: 2 sources, combinational output
  logic [1:0]         vld_in_b;
  logic [1:0]         accept_b;
  logic [1:0][RW-1:0] sresp_b;
  logic               valid_b;
  logic               acc_b;
  logic [RW-1:0]      data_b;
  logic [1:0]         grant_b;

  pzcorebus_response_arbiter #(
    .BUS_CONFIG ('0), .SLAVES (3), .REGISTERED_OUTPUT (1)
  ) dut_a (
    .i_clk (clk), .i_rst (rst),
    .i_sresp_valid (vld_in_a), .o_mresp_accept (accept_a), .i_sresp (sresp_a),
    .o_sresp_valid (valid_a), .i_mresp_accept (acc_a), .o_sresp (data_a),
    .o_grant (grant_a)
  );

  pzcorebus_response_arbiter #(
    .BUS_CONFIG ('0), .SLAVES (2), .REGISTERED_OUTPUT (0)
  ) dut_b (
    .i_clk (clk), .i_rst (rst),
    .i_sresp_valid (vld_in_b), .o_mresp_accept (accept_b), .i_sresp (sresp_b),
    .o_sresp_valid (valid_b), .i_mresp_accept (acc_b), .o_sresp (data_b),
    .o_grant (grant_b)
  );

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] pq_a [3][$];
  logic [RW-1:0] pq_b [2][$];
  logic [RW-1:0] exp_a [$];
  logic [RW-1:0] exp_b [$];
  logic [2:0]    acc_s_a = '0;
  logic [1:0]    acc_s_b = '0;

  function automatic logic [RW-1:0] mk(input int src, input int seq, input bit last);
    return {last, 4'(src), 4'(src), 12'(seq)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (exp_a.size() != 0 || exp_b.size() != 0); i++)
      @(negedge clk);
    chk("drain_a_left", exp_a.size(), 0);
    chk("drain_b_left", exp_b.size(), 0);
  endtask

  // Source models: hold valid/data until accepted; the accept sampled at the
  // preceding negedge retires the head beat.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < 3; p++) begin
      if (acc_s_a[p] && pq_a[p].size() > 0) void'(pq_a[p].pop_front());
      vld_in_a[p] = (pq_a[p].size() > 0);
      sresp_a[p]  = (pq_a[p].size() > 0) ? pq_a[p][0] : '0;
    end
    for (int p = 0; p < 2; p++) begin
      if (acc_s_b[p] && pq_b[p].size() > 0) void'(pq_b[p].pop_front());
      vld_in_b[p] = (pq_b[p].size() > 0);
      sresp_b[p]  = (pq_b[p].size() > 0) ? pq_b[p][0] : '0;
    end
  end

  // Monitor: scoreboard pops on every output transfer.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    acc_s_a = accept_a;
    acc_s_b = accept_b;
    if (!rst && valid_a === 1'b1 && acc_a) begin
      if (exp_a.size() == 0) chk("mon_a_extra", data_a, '1);
      else begin
        e = exp_a.pop_front();
        chk("mon_a_beat", data_a, e);
      end
    end
    if (!rst && valid_b === 1'b1 && acc_b) begin
      if (exp_b.size() == 0) chk("mon_b_extra", data_b, '1);
      else begin
        e = exp_b.pop_front();
        chk("mon_b_beat", data_b, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    acc_a = 1'b1;
    acc_b = 1'b0;
    vld_in_a = '0; sresp_a = '0;
    vld_in_b = '0; sresp_b = '0;

    // Reset with all sources valid; then round robin 0,1,2,0,1,2
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 3; p++) begin
        pq_a[p].push_back(mk(p, r, 1'b1));
        exp_a.push_back(mk(p, r, 1'b1));
      end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid_a", valid_a, 0);
      chk("rst_accept_a", accept_a, 0);
      chk("rst_grant_a", grant_a, 0);
      chk("rst_accept_b", accept_b, 0);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_accept", accept_a, 3'b001);
    chk("first_no_out", valid_a, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_tput_valid", valid_a, 1);
      if (i == 0) chk("rr_grant_second", grant_a, 3'b010);
    end
    @(negedge clk);
    chk("rr_idle_after", valid_a, 0);
    drain();

    // Burst lock: 4-beat burst on port 0, port 1 waiting
    for (int b = 0; b < 4; b++) begin
      pq_a[0].push_back(mk(0, 2 + b, b == 3));
      exp_a.push_back(mk(0, 2 + b, b == 3));
    end
    pq_a[1].push_back(mk(1, 2, 1'b1));
    exp_a.push_back(mk(1, 2, 1'b1));
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lock_accept", accept_a, 3'b001);
    end
    @(negedge clk);
    chk("lock_next_port1", accept_a, 3'b010);
    drain();

    // Skid full: pointer now at 2, so order is 2,0,1
    tick();
    acc_a = 1'b0;
    for (int p = 0; p < 3; p++) pq_a[p].push_back(mk(p, 6, 1'b1));
    exp_a.push_back(mk(2, 6, 1'b1));
    exp_a.push_back(mk(0, 6, 1'b1));
    exp_a.push_back(mk(1, 6, 1'b1));
    tick();
    @(negedge clk); chk("skid_acc1", accept_a, 3'b100);
    @(negedge clk); chk("skid_acc2", accept_a, 3'b001);
    @(negedge clk); chk("skid_full_acc", accept_a, 3'b000);
    chk("skid_full_valid", valid_a, 1);
    chk("skid_full_head", data_a, mk(2, 6, 1'b1));
    chk("skid_held_grant", grant_a, 3'b010);
    @(negedge clk); chk("skid_full_acc2", accept_a, 3'b000);
    chk("skid_held_grant2", grant_a, 3'b010);
    tick();
    acc_a = 1'b1;
    drain();

    // Reset mid-burst from port 1 (two beats buffered, then reset)
    tick();
    acc_a = 1'b0;
    for (int b = 0; b < 4; b++) pq_a[1].push_back(mk(1, 7 + b, b == 3));
    tick();
    @(negedge clk); chk("mid_acc1", accept_a, 3'b010);
    @(negedge clk); chk("mid_acc2", accept_a, 3'b010);
    @(negedge clk); chk("mid_full", accept_a, 3'b000);
    tick();
    rst = 1'b1;
    for (int p = 0; p < 3; p++) pq_a[p].delete();
    tick();
    tick();
    @(negedge clk);
    chk("mid_rst_valid", valid_a, 0);
    tick();
    rst   = 1'b0;
    acc_a = 1'b1;
    pq_a[0].push_back(mk(0, 11, 1'b1));
    pq_a[1].push_back(mk(1, 11, 1'b1));
    exp_a.push_back(mk(0, 11, 1'b1));
    exp_a.push_back(mk(1, 11, 1'b1));
    tick();
    @(negedge clk);
    chk("post_rst_grant0", accept_a, 3'b001);
    drain();

    // Backpressure stability on combinational output
    pq_b[1].push_back(mk(1, 20, 1'b1));
    exp_b.push_back(mk(1, 20, 1'b1));
    exp_b.push_back(mk(0, 20, 1'b1));
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", valid_b, 1);
      chk("bp_grant", grant_b, 2'b10);
      chk("bp_data", data_b, mk(1, 20, 1'b1));
      chk("bp_accept", accept_b, 2'b00);
      if (c == 0) pq_b[0].push_back(mk(0, 20, 1'b1));
    end
    tick();
    acc_b = 1'b1;
    @(negedge clk);
    chk("bp_release_grant", grant_b, 2'b10);
    drain();

    @(negedge clk);
    chk("end_idle_a", valid_a, 0);
    chk("end_idle_b", valid_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
